mem_responder: RTL and testbench

- Responder (cache side) of the datapath/cache interface. Serves the processor datapath's instruction-fetch and data load/store requests.
- Arbitrates the two request streams onto one single-port RAM with variable wait states, returning single-cycle ihit/dhit pulses with the loaded word.
- Sits between the datapath and the RAM/memory model. It is the blocking, cacheless baseline that later caches replace.

---
 rtl/cpu_types_pkg.sv | 7 +
 rtl/mem_wait_timer.sv | 19 +
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath/cache types for the memory responder and future caches
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP, HALT} mresp_state_t;
  // Byte-offset bits within a word; any set bit means a misaligned word access
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-state counter with clear/enable and a terminal-count flag
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] count;
  assign tc = count == CW'(TIMEOUT - 1);
  // Count access cycles, saturating at terminal count until cleared
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en && !tc) count <= count + 1'b1;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: blocking arbiter of fetch and data requests onto a single-port wait-state RAM
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  word_t             dmemstore,
  input  logic              halt,
  output logic              ihit,
  output word_t             imemload,
  output logic              dhit,
  output word_t             dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  logic              ram_ready,
  output logic              err,
  output logic              halted
);
  mresp_state_t      state;
  logic              wr, tc, in_acc, i_mis, d_mis;
  logic [ADDR_W-1:0] i_addr, d_addr;
  assign in_acc = (state == DACC) || (state == IACC);
  assign i_mis  = |(imemaddr[1:0] & WORD_ALIGN_MASK);
  assign d_mis  = |(dmemaddr[1:0] & WORD_ALIGN_MASK);
  assign i_addr = {imemaddr[ADDR_W-1:2], imemaddr[1:0] & ~WORD_ALIGN_MASK};
  assign d_addr = {dmemaddr[ADDR_W-1:2], dmemaddr[1:0] & ~WORD_ALIGN_MASK};
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(CLK),
    .rst(RST),
    .clr(!in_acc),
    .en (in_acc),
    .tc (tc)
  );
  // Responder FSM: latch a request in IDLE, hold RAM strobes until ready or timeout, pulse one hit
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state    <= IDLE;
      wr       <= 1'b0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      imemload <= '0;
      dmemload <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      err      <= 1'b0;
      halted   <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE:
          if (halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (dmemREN || dmemWEN) begin
            state    <= DACC;
            wr       <= dmemWEN;
            ramWEN   <= dmemWEN;
            ramREN   <= !dmemWEN;
            ramaddr  <= d_addr;
            ramstore <= dmemstore;
            err      <= err | d_mis;
          end else if (imemREN) begin
            state   <= IACC;
            wr      <= 1'b0;
            ramREN  <= 1'b1;
            ramaddr <= i_addr;
            err     <= err | i_mis;
          end
        DACC, IACC:
          if (ram_ready || tc) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            err    <= err | !ram_ready;
            state  <= (state == DACC) ? DRESP : IRESP;
            dhit   <= state == DACC;
            ihit   <= state == IACC;
            if (state == DACC) dmemload <= (ram_ready && !wr) ? ramload : '0;
            else imemload <= ram_ready ? ramload : '0;
          end
        DRESP, IRESP: state <= IDLE;
        HALT:         state <= HALT;
        default:      state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenario tests for mem_responder
module tb_mem_responder;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        imemREN = 0, dmemREN = 0, dmemWEN = 0, halt = 0, ram_ready = 0;
  logic [31:0] imemaddr = 0, dmemaddr = 0, dmemstore = 0, ramload = 0;
  logic        ihit, dhit, ramREN, ramWEN, err, halted;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  int          checks = 0, errors = 0;

  mem_responder #(.TIMEOUT(64), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({ihit, dhit, ramREN, ramWEN, err, halted, ramaddr, ramstore, imemload, dmemload} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ihit=%b dhit=%b ren=%b wen=%b err=%b halted=%b addr=%h, required all 0",
               ihit, dhit, ramREN, ramWEN, err, halted, ramaddr);
    end
    RST = 1'b0;
    tick();
    checks++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got ren=%b wen=%b ihit=%b dhit=%b, required 0000", ramREN, ramWEN, ihit, dhit);
    end
  endtask

  task automatic test_fetch();
    imemREN = 1; imemaddr = 32'h40; ramload = 32'h8C220004;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ramREN, ramWEN, ihit, ramaddr} !== {3'b100, 32'h40}) begin
        errors++;
        $display("FAIL fetch_wait%0d: got ren=%b wen=%b ihit=%b addr=%h, required 1 0 0 00000040", i, ramREN, ramWEN, ihit, ramaddr);
      end
      if (i == 2) ram_ready = 1;
      tick();
    end
    checks++;
    if ({ihit, dhit, ramREN, imemload} !== {3'b100, 32'h8C220004}) begin
      errors++;
      $display("FAIL fetch_hit: got ihit=%b dhit=%b ren=%b load=%h, required 1 0 0 8c220004", ihit, dhit, ramREN, imemload);
    end
    imemREN = 0; ram_ready = 0;
    tick();
    checks++;
    if ({ihit, dhit, ramREN} !== 3'b0) begin
      errors++;
      $display("FAIL fetch_one_pulse: got ihit=%b dhit=%b ren=%b, required 000", ihit, dhit, ramREN);
    end
  endtask

  task automatic test_simultaneous();
    imemREN = 1; imemaddr = 32'h44; dmemREN = 1; dmemaddr = 32'h100;
    tick();
    checks++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL sim_data_first: got ren=%b addr=%h, required 1 00000100", ramREN, ramaddr);
    end
    ram_ready = 1; ramload = 32'h11112222;
    tick();
    checks++;
    if ({dhit, ihit, dmemload} !== {2'b10, 32'h11112222}) begin
      errors++;
      $display("FAIL sim_dhit: got dhit=%b ihit=%b load=%h, required 1 0 11112222", dhit, ihit, dmemload);
    end
    dmemREN = 0; ram_ready = 0;
    tick();
    checks++;
    if ({dhit, ihit, ramREN} !== 3'b0) begin
      errors++;
      $display("FAIL sim_gap: got dhit=%b ihit=%b ren=%b, required 000", dhit, ihit, ramREN);
    end
    tick();
    checks++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h44}) begin
      errors++;
      $display("FAIL sim_fetch_second: got ren=%b addr=%h, required 1 00000044", ramREN, ramaddr);
    end
    ram_ready = 1; ramload = 32'h33334444;
    tick();
    checks++;
    if ({ihit, dhit, imemload} !== {2'b10, 32'h33334444}) begin
      errors++;
      $display("FAIL sim_ihit: got ihit=%b dhit=%b load=%h, required 1 0 33334444", ihit, dhit, imemload);
    end
    imemREN = 0; ram_ready = 0;
    tick();
  endtask

  task automatic test_store();
    dmemWEN = 1; dmemaddr = 32'h200; dmemstore = 32'hDEADBEEF;
    tick();
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h200, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL store_drive: got wen=%b ren=%b addr=%h data=%h, required 1 0 00000200 deadbeef", ramWEN, ramREN, ramaddr, ramstore);
    end
    dmemstore = 32'h12345678; dmemaddr = 32'h300;
    tick();
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h200, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL store_latched: got wen=%b ren=%b addr=%h data=%h, required 1 0 00000200 deadbeef", ramWEN, ramREN, ramaddr, ramstore);
    end
    ram_ready = 1;
    tick();
    checks++;
    if ({dhit, ihit, ramWEN, ramREN} !== 4'b1000) begin
      errors++;
      $display("FAIL store_dhit: got dhit=%b ihit=%b wen=%b ren=%b, required 1000", dhit, ihit, ramWEN, ramREN);
    end
    dmemWEN = 0; ram_ready = 0;
    tick();
  endtask

  task automatic test_timeout();
    dmemREN = 1; dmemaddr = 32'h300; ramload = 32'hFFFFFFFF;
    tick();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({ramREN, dhit, err} !== 3'b100) begin
        errors++;
        $display("FAIL timeout_wait%0d: got ren=%b dhit=%b err=%b, required 100", i, ramREN, dhit, err);
      end
      tick();
    end
    checks++;
    if ({dhit, err, ramREN, dmemload} !== {3'b110, 32'h0}) begin
      errors++;
      $display("FAIL timeout_hit: got dhit=%b err=%b ren=%b load=%h, required 1 1 0 00000000", dhit, err, ramREN, dmemload);
    end
    dmemREN = 0;
    repeat (2) tick();
    checks++;
    if ({dhit, err, ramREN} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_sticky: got dhit=%b err=%b ren=%b, required 010", dhit, err, ramREN);
    end
  endtask

  task automatic test_reset_mid_access();
    dmemREN = 1; dmemaddr = 32'h400;
    tick();
    checks++;
    if (ramREN !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got ren=%b, required 1", ramREN);
    end
    #2 RST = 1;
    #1;
    checks++;
    if ({ramREN, err, dhit} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_async: got ren=%b err=%b dhit=%b, required 000", ramREN, err, dhit);
    end
    dmemREN = 0;
    #1 RST = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dhit, ihit, ramREN, err} !== 4'b0) begin
        errors++;
        $display("FAIL rst_mid_after%0d: got dhit=%b ihit=%b ren=%b err=%b, required 0000", i, dhit, ihit, ramREN, err);
      end
    end
  endtask

  task automatic test_misaligned();
    imemREN = 1; imemaddr = 32'h4A;
    tick();
    checks++;
    if ({err, ramREN, ramaddr} !== {2'b11, 32'h48}) begin
      errors++;
      $display("FAIL misaligned_access: got err=%b ren=%b addr=%h, required 1 1 00000048", err, ramREN, ramaddr);
    end
    ram_ready = 1; ramload = 32'hCAFEF00D;
    tick();
    checks++;
    if ({ihit, err, imemload} !== {2'b11, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL misaligned_hit: got ihit=%b err=%b load=%h, required 1 1 cafef00d", ihit, err, imemload);
    end
    imemREN = 0; ram_ready = 0;
    tick();
  endtask

  task automatic test_halt();
    imemREN = 1; imemaddr = 32'h50;
    tick();
    halt = 1;
    tick();
    checks++;
    if ({ramREN, ihit, halted} !== 3'b100) begin
      errors++;
      $display("FAIL halt_inflight: got ren=%b ihit=%b halted=%b, required 100", ramREN, ihit, halted);
    end
    ram_ready = 1; ramload = 32'h0BADF00D;
    tick();
    checks++;
    if ({ihit, halted, imemload} !== {2'b10, 32'h0BADF00D}) begin
      errors++;
      $display("FAIL halt_completes: got ihit=%b halted=%b load=%h, required 1 0 0badf00d", ihit, halted, imemload);
    end
    ram_ready = 0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({halted, ramREN, ramWEN, ihit, dhit} !== 5'b10000) begin
        errors++;
        $display("FAIL halt_quiesced%0d: got halted=%b ren=%b wen=%b ihit=%b dhit=%b, required 10000", i, halted, ramREN, ramWEN, ihit, dhit);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_timeout();
    test_reset_mid_access();
    test_misaligned();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(negedge CLK)
    if (!RST && ihit && dhit) begin
      checks++;
      errors++;
      $display("FAIL both_hits: got ihit=1 dhit=1, required never both");
    end
endmodule
